smm_job_sched: RTL and testbench
================================

// Module: smm_job_sched
// PURPOSE
// - Shares one sparse-matrix-multiply engine between NREQ requesters, one whole job at a time.
// - Round-robin arbitration. Muxes the granted requester's size/A/B triplet streams into the engine.
// - Returns engine results to the owner and signals job completion.
// - Sits between the client ports and the SMM engine.
// PARAMETERS
// - NREQ      2     number of requesters (ptr/index width = $clog2(NREQ), min 1)
// - WDOG_CYC  4096  watchdog limit in cycles for WAIT_OUT/DRAIN (used only with macro)
// PORTS
// - clk            in   1         clock, rising edge
// - rst            in   1         asynchronous, active-high reset
// - req            in   NREQ      job request, level; bit i = requester i
// - gnt            out  NREQ      one-hot grant, held from grant to done
// - done           out  NREQ      1-cycle completion pulse to owner
// - err            out  NREQ      sticky: requester drove stream valids while not granted
// - rq_valid_size  in   NREQ      per-requester size strobe
// - rq_size        in   NREQ      per-requester size bit
// - rq_valid_a/b   in   NREQ      per-requester A/B triplet valid
// - rq_row_a/b, rq_col_a/b  in  5*NREQ  packed; slice [5i+4:5i] = requester i
// - rq_val_a/b     in   4*NREQ    packed; slice [4i+3:4i]
// - eng_valid_size, eng_size, eng_valid_a/b  out  1   to engine
// - eng_row_a/b, eng_col_a/b  out  5;  eng_val_a/b  out  4   to engine
// - eng_out_valid  in   1         engine result valid
// - eng_out_row/col  in 5;  eng_out_val  in  9   engine result
// - rsp_valid      out  NREQ      result valid, owner bit only
// - rsp_row/col    out  5;  rsp_val  out  9   shared result bus
// - rsp_cnt        out  6         results in last job; valid with done
// BEHAVIOUR
// - Reset: state=IDLE, ptr=0. All outputs 0: gnt, done, err, eng_*, rsp_*, rsp_cnt.
// - FSM states: IDLE -> GRANT -> LOAD -> WAIT_OUT -> DRAIN -> IDLE.
// - IDLE: sample req. First set bit at/after ptr, cyclic search, wins. gnt asserts next cycle.
//   - No req: stay in IDLE.
// - GRANT: wait for the owner's rq_valid_size. Forward it, then go to LOAD.
// - LOAD: forward the owner's rq_valid_a/b with their fields.
//   - Exit to WAIT_OUT on the first cycle with both owner valids low, after at least one a or b valid.
// - WAIT_OUT: wait for eng_out_valid=1, then go to DRAIN.
// - DRAIN: relay each result, rsp_cnt += 1.
//   - First cycle with eng_out_valid=0: done[owner]=1 (rsp_cnt final), gnt=0, ptr=(owner+1)%NREQ, go to IDLE.
// - Latency: requester->engine and engine->rsp are each exactly 1 registered cycle.
//   - eng_* and rsp_* are 0 when not forwarding.
// - Non-owner stream valids are dropped and set that requester's err bit. err clears only on rst.
// - req drop while granted: ignored; the job runs to done.
// - A requester may re-request the same cycle as its done; it is arbitrated next IDLE cycle at the rotated ptr.
// - rsp_cnt saturates at 63.
// - rst mid-job: immediate return to IDLE. Engine contents are not cleared; the next size strobe clears them.
// CONFIGURATION
// - SMM_SCHED_WDOG_EN defined:
//   - 13-bit counter runs in WAIT_OUT+DRAIN, reset on state entry to WAIT_OUT.
//   - On reaching WDOG_CYC: done[owner]=1, err[owner]=1, rsp_cnt = results so far, go to IDLE, ptr rotates.
//   - Covers jobs where the engine emits no result.
// - SMM_SCHED_WDOG_EN undefined: no counter. A job with no eng_out_valid holds gnt indefinitely.
// TESTING
// - Single job: req=01, size=0, 2 A + 2 B triplets, engine returns 3 results -> gnt=01; rsp_valid=01 x3; done=01 with rsp_cnt=3; ptr=1.
// - Contention: req=11 from reset -> gnt=01 first; after done, gnt=10; with req still 11 after that, gnt=01.
// - Intruder: requester 1 pulses rq_valid_a while gnt=01 -> eng_valid_a unaffected; err=10 and stays 10 after job end.
// - Pipeline: owner valid_a at cycle t -> eng_valid_a at t+1 with identical row/col/val; eng_out_valid at t -> rsp_valid at t+1.
// - Reset mid-DRAIN: rst high for 1 cycle -> all outputs 0 the same cycle; next req=10 gets gnt=10 (ptr=0 search).
// - Watchdog (macro on, WDOG_CYC=16): engine never raises out_valid -> done=owner, err=owner, rsp_cnt=0, 16 cycles after WAIT_OUT entry.

Source files
------------

// File: rtl/smm_job_sched.sv
// smm_job_sched: round-robin, whole-job sharing of one SMM engine among NREQ requesters.
// Define SMM_SCHED_WDOG_EN to end a job stalled in WAIT_OUT/DRAIN after WDOG_CYC cycles.
module smm_job_sched #(
  parameter int NREQ     = 2,
  parameter int WDOG_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  input  logic [NREQ-1:0]   rq_valid_size,
  input  logic [NREQ-1:0]   rq_size,
  input  logic [NREQ-1:0]   rq_valid_a,
  input  logic [NREQ-1:0]   rq_valid_b,
  input  logic [5*NREQ-1:0] rq_row_a,
  input  logic [5*NREQ-1:0] rq_col_a,
  input  logic [5*NREQ-1:0] rq_row_b,
  input  logic [5*NREQ-1:0] rq_col_b,
  input  logic [4*NREQ-1:0] rq_val_a,
  input  logic [4*NREQ-1:0] rq_val_b,
  output logic              eng_valid_size,
  output logic              eng_size,
  output logic              eng_valid_a,
  output logic              eng_valid_b,
  output logic [4:0]        eng_row_a,
  output logic [4:0]        eng_col_a,
  output logic [4:0]        eng_row_b,
  output logic [4:0]        eng_col_b,
  output logic [3:0]        eng_val_a,
  output logic [3:0]        eng_val_b,
  input  logic              eng_out_valid,
  input  logic [4:0]        eng_out_row,
  input  logic [4:0]        eng_out_col,
  input  logic [8:0]        eng_out_val,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [4:0]        rsp_row,
  output logic [4:0]        rsp_col,
  output logic [8:0]        rsp_val,
  output logic [5:0]        rsp_cnt
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [2:0] {IDLE, GRANT, LOAD, WAIT_OUT, DRAIN} state_t;
  state_t          state_q;
  logic [IW-1:0]   ptr_q, own_q, win_d, nxt;
  logic            hit_d, seen_q, busy;
  logic [NREQ-1:0] gnt_q, done_q, err_q, rsp_v_q;
  logic [1:0]      eng_sz_q;
  logic [14:0]     eng_a_q, eng_b_q;
  logic [18:0]     rsp_q;
  logic [5:0]      cnt_q;
`ifdef SMM_SCHED_WDOG_EN
  logic [12:0]     wd_q;
`endif
  if (WDOG_CYC < 1 || WDOG_CYC > 8191) begin : g_bad_wdog
    $error("WDOG_CYC must fit the 13-bit watchdog counter");
  end
  assign gnt = gnt_q;
  assign done = done_q;
  assign err = err_q;
  assign {eng_valid_size, eng_size} = eng_sz_q;
  assign {eng_valid_a, eng_row_a, eng_col_a, eng_val_a} = eng_a_q;
  assign {eng_valid_b, eng_row_b, eng_col_b, eng_val_b} = eng_b_q;
  assign rsp_valid = rsp_v_q;
  assign {rsp_row, rsp_col, rsp_val} = rsp_q;
  assign rsp_cnt = cnt_q;
  assign busy = state_q == WAIT_OUT || state_q == DRAIN;
  assign nxt = own_q == IW'(NREQ - 1) ? '0 : own_q + 1'b1;
  // descending scan so the nearest requester at/after ptr is assigned last
  always_comb begin
    win_d = ptr_q;
    hit_d = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr_q) + k) % NREQ]) begin
        win_d = IW'((int'(ptr_q) + k) % NREQ);
        hit_d = 1'b1;
      end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      own_q <= '0;
      seen_q <= 1'b0;
      gnt_q <= '0;
      done_q <= '0;
      err_q <= '0;
      eng_sz_q <= '0;
      eng_a_q <= '0;
      eng_b_q <= '0;
      rsp_v_q <= '0;
      rsp_q <= '0;
      cnt_q <= '0;
`ifdef SMM_SCHED_WDOG_EN
      wd_q <= '0;
`endif
    end else begin
      done_q <= '0;
      eng_sz_q <= '0;
      eng_a_q <= '0;
      eng_b_q <= '0;
      rsp_v_q <= '0;
      rsp_q <= '0;
      err_q <= err_q | ((rq_valid_size | rq_valid_a | rq_valid_b) & ~gnt_q);
      if (busy && eng_out_valid) begin
        rsp_v_q <= gnt_q;
        rsp_q <= {eng_out_row, eng_out_col, eng_out_val};
        cnt_q <= cnt_q + 6'(cnt_q != 6'd63);
      end
      case (state_q)
        IDLE: if (hit_d) begin
          own_q <= win_d;
          gnt_q <= NREQ'(1) << win_d;
          cnt_q <= '0;
          seen_q <= 1'b0;
          state_q <= GRANT;
        end
        GRANT: if (rq_valid_size[own_q]) begin
          eng_sz_q <= {1'b1, rq_size[own_q]};
          state_q <= LOAD;
        end
        LOAD: begin
          if (rq_valid_a[own_q])
            eng_a_q <= {1'b1, rq_row_a[5*own_q +: 5], rq_col_a[5*own_q +: 5], rq_val_a[4*own_q +: 4]};
          if (rq_valid_b[own_q])
            eng_b_q <= {1'b1, rq_row_b[5*own_q +: 5], rq_col_b[5*own_q +: 5], rq_val_b[4*own_q +: 4]};
          seen_q <= seen_q | rq_valid_a[own_q] | rq_valid_b[own_q];
          if (seen_q && !rq_valid_a[own_q] && !rq_valid_b[own_q]) state_q <= WAIT_OUT;
        end
        WAIT_OUT: if (eng_out_valid) state_q <= DRAIN;
        DRAIN: if (!eng_out_valid) begin
          done_q <= gnt_q;
          gnt_q <= '0;
          ptr_q <= nxt;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef SMM_SCHED_WDOG_EN
      wd_q <= busy ? wd_q + 13'd1 : 13'd0;
      if (busy && wd_q == 13'(WDOG_CYC - 1)) begin
        done_q <= gnt_q;
        err_q[own_q] <= 1'b1;
        gnt_q <= '0;
        ptr_q <= nxt;
        state_q <= IDLE;
      end
`endif
    end
  end
endmodule

// File: tb/tb_smm_job_sched.sv
// tb_smm_job_sched: job table with hand-derived expectations, directed corner sequences,
// and randomized jobs scored against a job-level round-robin model.
module tb_smm_job_sched;
  localparam int WD = 100;
  logic clk = 1'b0, rst;
  logic [1:0] req, gnt, done, err, rq_valid_size, rq_size, rq_valid_a, rq_valid_b, rsp_valid;
  logic [9:0] rq_row_a, rq_col_a, rq_row_b, rq_col_b;
  logic [7:0] rq_val_a, rq_val_b;
  logic eng_valid_size, eng_size, eng_valid_a, eng_valid_b, eng_out_valid;
  logic [4:0] eng_row_a, eng_col_a, eng_row_b, eng_col_b, eng_out_row, eng_out_col, rsp_row, rsp_col;
  logic [3:0] eng_val_a, eng_val_b;
  logic [8:0] eng_out_val, rsp_val;
  logic [5:0] rsp_cnt;
  int checks = 0, failures = 0;
  logic [1:0] err_m = 2'b00;
  int ptr_m = 0;

  smm_job_sched #(.NREQ(2), .WDOG_CYC(WD)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .done(done), .err(err),
    .rq_valid_size(rq_valid_size), .rq_size(rq_size), .rq_valid_a(rq_valid_a), .rq_valid_b(rq_valid_b),
    .rq_row_a(rq_row_a), .rq_col_a(rq_col_a), .rq_row_b(rq_row_b), .rq_col_b(rq_col_b),
    .rq_val_a(rq_val_a), .rq_val_b(rq_val_b),
    .eng_valid_size(eng_valid_size), .eng_size(eng_size), .eng_valid_a(eng_valid_a), .eng_valid_b(eng_valid_b),
    .eng_row_a(eng_row_a), .eng_col_a(eng_col_a), .eng_row_b(eng_row_b), .eng_col_b(eng_col_b),
    .eng_val_a(eng_val_a), .eng_val_b(eng_val_b),
    .eng_out_valid(eng_out_valid), .eng_out_row(eng_out_row), .eng_out_col(eng_out_col), .eng_out_val(eng_out_val),
    .rsp_valid(rsp_valid), .rsp_row(rsp_row), .rsp_col(rsp_col), .rsp_val(rsp_val), .rsp_cnt(rsp_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] rq; int nres; logic [1:0] eg; logic [5:0] ecnt; } vec_t;
  vec_t tbl[7];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rq_valid_size = '0; rq_size = '0; rq_valid_a = '0; rq_valid_b = '0;
    rq_row_a = '0; rq_col_a = '0; rq_row_b = '0; rq_col_b = '0; rq_val_a = '0; rq_val_b = '0;
  endtask

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int o);
    return 2'(1 << o);
  endfunction

  function automatic logic [95:0] all_out();
    return {gnt, done, err, eng_valid_size, eng_size, eng_valid_a, eng_row_a, eng_col_a, eng_val_a,
            eng_valid_b, eng_row_b, eng_col_b, eng_val_b, rsp_valid, rsp_row, rsp_col, rsp_val, rsp_cnt};
  endfunction

  task automatic grant_chk(input logic [1:0] r, input logic [1:0] eg);
    req = r;
    cyc();
    chk("gnt", gnt, eg);
    chk("done_low", done, 2'b00);
  endtask

  task automatic load(input int o, input int n, input bit intr);
    int d;
    logic sz, va, vb;
    logic [4:0] ra, ca, rb, cb;
    logic [3:0] xa, xb;
    d = $urandom_range(0, 2);
    sz = 1'($urandom);
    repeat (d) begin
      cyc();
      chk("size_wait", eng_valid_size, 1'b0);
    end
    rq_valid_size[o] = 1'b1;
    rq_size[o] = sz;
    cyc();
    chk("size_fwd", {eng_valid_size, eng_size}, {1'b1, sz});
    clr();
    for (int i = 0; i < n; i++) begin
      va = 1'($urandom);
      vb = va ? 1'($urandom) : 1'b1;
      {ra, ca, xa, rb, cb, xb} = 28'($urandom);
      rq_valid_a[o] = va; rq_row_a[5*o +: 5] = ra; rq_col_a[5*o +: 5] = ca; rq_val_a[4*o +: 4] = xa;
      rq_valid_b[o] = vb; rq_row_b[5*o +: 5] = rb; rq_col_b[5*o +: 5] = cb; rq_val_b[4*o +: 4] = xb;
      if (intr && i == 0) begin
        rq_valid_a[1-o] = 1'b1;
        rq_row_a[5*(1-o) +: 5] = ~ra;
        rq_val_a[4*(1-o) +: 4] = ~xa;
        err_m[1-o] = 1'b1;
      end
      cyc();
      chk("eng_ab", {eng_valid_a, eng_row_a, eng_col_a, eng_val_a, eng_valid_b, eng_row_b, eng_col_b, eng_val_b},
          {va, va ? ra : 5'd0, va ? ca : 5'd0, va ? xa : 4'd0, vb, vb ? rb : 5'd0, vb ? cb : 5'd0, vb ? xb : 4'd0});
      clr();
    end
    cyc();
    chk("load_exit", {eng_valid_a, eng_valid_b}, 2'b00);
  endtask

  task automatic results(input int o, input int nres, input logic [5:0] ecnt);
    int w;
    logic [18:0] d;
    w = $urandom_range(0, 3);
    repeat (w) begin
      cyc();
      chk("rsp_wait", rsp_valid, 2'b00);
    end
    for (int i = 0; i < nres; i++) begin
      d = 19'($urandom);
      eng_out_valid = 1'b1;
      {eng_out_row, eng_out_col, eng_out_val} = d;
      cyc();
      chk("rsp", {rsp_valid, rsp_row, rsp_col, rsp_val}, {oh(o), d});
    end
    eng_out_valid = 1'b0;
    {eng_out_row, eng_out_col, eng_out_val} = '0;
    cyc();
    chk("done", {done, rsp_cnt, gnt, rsp_valid}, {oh(o), ecnt, 2'b00, 2'b00});
    ptr_m = (o + 1) % 2;
  endtask

  initial begin
    logic [1:0] rv;
    int o, nres;
    bit intr;
    tbl[0] = '{2'b01, 3, 2'b01, 6'd3};
    tbl[1] = '{2'b11, 1, 2'b10, 6'd1};
    tbl[2] = '{2'b11, 2, 2'b01, 6'd2};
    tbl[3] = '{2'b10, 4, 2'b10, 6'd4};
    tbl[4] = '{2'b01, 65, 2'b01, 6'd63};
    tbl[5] = '{2'b01, 64, 2'b01, 6'd63};
    tbl[6] = '{2'b11, 63, 2'b10, 6'd63};
    rst = 1'b1; req = '0; clr();
    eng_out_valid = 1'b0;
    {eng_out_row, eng_out_col, eng_out_val} = '0;
    cyc(); cyc();
    chk("reset_outs", all_out(), 96'd0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      o = tbl[i].eg[1] ? 1 : 0;
      grant_chk(tbl[i].rq, tbl[i].eg);
      load(o, 2, 1'b0);
      results(o, tbl[i].nres, tbl[i].ecnt);
    end
    // intruder: requester 1 streams while requester 0 owns the engine
    grant_chk(2'b01, 2'b01);
    load(0, 2, 1'b1);
    chk("err_intr", err, 2'b10);
    results(0, 1, 6'd1);
    chk("err_sticky", err, 2'b10);
    // reset in the middle of DRAIN
    grant_chk(2'b11, 2'b10);
    load(1, 1, 1'b0);
    eng_out_valid = 1'b1;
    {eng_out_row, eng_out_col, eng_out_val} = 19'h1abcd;
    cyc(); cyc();
    chk("drain_live", rsp_valid, 2'b10);
    rst = 1'b1;
    #1;
    chk("rst_async", all_out(), 96'd0);
    cyc();
    rst = 1'b0;
    eng_out_valid = 1'b0;
    {eng_out_row, eng_out_col, eng_out_val} = '0;
    err_m = 2'b00;
    ptr_m = 0;
    grant_chk(2'b10, 2'b10);
    load(1, 1, 1'b0);
    results(1, 2, 6'd2);
    for (int j = 0; j < 40; j++) begin
      rv = 2'($urandom_range(1, 3));
      o = rv[ptr_m] ? ptr_m : 1 - ptr_m;
      intr = $urandom_range(0, 3) == 0;
      nres = $urandom_range(1, 6);
      grant_chk(rv, oh(o));
      load(o, $urandom_range(1, 4), intr);
      chk("err_rand", err, err_m);
      results(o, nres, 6'(nres));
    end
`ifdef SMM_SCHED_WDOG_EN
    o = ptr_m;
    grant_chk(oh(o), oh(o));
    load(o, 1, 1'b0);
    repeat (WD - 1) begin
      cyc();
      chk("wdog_early", done, 2'b00);
    end
    cyc();
    err_m[o] = 1'b1;
    chk("wdog", {done, err, rsp_cnt, gnt}, {oh(o), err_m, 6'd0, 2'b00});
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
